// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared opcode, field-width and register-code definitions for the core
package instruction_fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int OPC_W        = 4;
    localparam int OPR_W        = 24;
    localparam int FETCH_INSN_W = OPC_W + OPR_W;

    typedef enum logic [OPC_W-1:0] {
        OPC_LOAD  = 4'h0,
        OPC_STORE = 4'h1,
        OPC_ADD   = 4'h2,
        OPC_SUB   = 4'h3,
        OPC_AND   = 4'h4,
        OPC_OR    = 4'h5,
        OPC_XOR   = 4'h6,
        OPC_SHL   = 4'h7,
        OPC_SHR   = 4'h8,
        OPC_JMP   = 4'h9,
        OPC_BEQ   = 4'hA,
        OPC_BNE   = 4'hB,
        OPC_NOP   = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        REG_R0 = 4'h0,
        REG_R1 = 4'h1,
        REG_R2 = 4'h2,
        REG_R3 = 4'h3,
        REG_SP = 4'hE,
        REG_LR = 4'hF
    } reg_code_e;

    // Bubble marker: NOP opcode with an all-zero operand field.
    localparam logic [FETCH_INSN_W-1:0] INSN_NOP = {OPC_NOP, {OPR_W{1'b0}}};

endpackage

// File: rtl/instruction_fetch_ff_en.sv
// rtl/instruction_fetch_ff_en.sv - parameterised D flip-flop with sync reset value and load enable
module fetch_ff_en #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= RST_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: PC, ROM address, instruction register, stall and branch flush
// Optional retired-fetch counter output oFetchCount under FETCH_COUNT_EN.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INSN_W = FETCH_INSN_W
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] oAddress,
    input  logic [INSN_W-1:0] iInstruction,
    input  logic              iStall,
    input  logic              iBranchTaken,
    input  logic [ADDR_W-1:0] iBranchTarget,
    output logic [INSN_W-1:0] oInstruction,
    output logic [ADDR_W-1:0] oInstrPC,
`ifdef FETCH_COUNT_EN
    output logic [31:0]       oFetchCount,
`endif
    output logic              oValid
);

    localparam logic [INSN_W-1:0] NOP_WORD = INSN_W'(INSN_NOP);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INSN_W-1:0] ir_d;
    logic              valid_d;
    logic              pipe_en;
    logic              fetch_en;

    // A branch overrides a stall; a normal fetch needs neither.
    assign pipe_en  = iBranchTaken | ~iStall;
    assign fetch_en = ~iBranchTaken & ~iStall;

    always_comb begin
        pc_d    = pc_q + ADDR_W'(1);
        ir_d    = iInstruction;
        valid_d = 1'b1;
        if (iBranchTaken) begin
            pc_d    = iBranchTarget;
            ir_d    = NOP_WORD;
            valid_d = 1'b0;
        end
    end

    fetch_ff_en #(.W(ADDR_W), .RST_VAL('0)) u_pc (
        .clk_i (Clock),
        .rst_i (Reset),
        .en_i  (pipe_en),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    fetch_ff_en #(.W(INSN_W), .RST_VAL(NOP_WORD)) u_ir (
        .clk_i (Clock),
        .rst_i (Reset),
        .en_i  (pipe_en),
        .d_i   (ir_d),
        .q_o   (oInstruction)
    );

    // Instruction PC only tracks real fetches; during a bubble it is meaningless.
    fetch_ff_en #(.W(ADDR_W), .RST_VAL('0)) u_instr_pc (
        .clk_i (Clock),
        .rst_i (Reset),
        .en_i  (fetch_en),
        .d_i   (pc_q),
        .q_o   (oInstrPC)
    );

    fetch_ff_en #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clk_i (Clock),
        .rst_i (Reset),
        .en_i  (pipe_en),
        .d_i   (valid_d),
        .q_o   (oValid)
    );

    assign oAddress = pc_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (fetch_en && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign oFetchCount = count_q;
`endif

endmodule
